sar_ctrl: RTL and testbench
===========================

Name: sar_ctrl

Overview:
Parametrised successive-approximation controller. It replaces the single-bit comparator-decision FSM with a full N-bit conversion sequencer. It drives the sample switch and the capacitive-DAC trial code, and resolves one bit per clock from the comparator. It publishes a registered result with a DONE pulse and supports single-shot and continuous conversion modes. It sits between the analog comparator/CDAC array and the digital readout.

Parameters:
WIDTH, 8, result and DAC code width in bits (>=2)
SAMPLE_CYCLES, 2, number of clock cycles SAMPLE is held high per conversion (>=1)

Ports:
CLK  input  1  clock
VRESET  input  1  reset (see Behaviour)
VSTART  input  1  request conversion; sampled in IDLE only
VENABLE  input  1  high = advance; low = freeze all state
VCONT  input  1  continuous mode: after DONE, restart sampling without a new VSTART
VCOMP  input  1  comparator output; 1 = analog input >= current DAC trial level
SAMPLE  output  1  sample-switch control, high during the SAMPLE state
DAC_CODE  output  WIDTH  trial code to the CDAC
BIT_SEL  output  WIDTH  one-hot index of the bit under trial; 0 outside CONVERT
BUSY  output  1  high in the SAMPLE and CONVERT states
DONE  output  1  one enabled cycle high when RESULT updates
RESULT  output  [WIDTH-1:0]  last completed conversion; held until the next DONE

Behaviour:
- Reset is VRESET, asynchronous, active-high. Clock is CLK, rising edge. All state is registered on CLK.
- Reset values: state=IDLE; SAMPLE=0; DAC_CODE=0; BIT_SEL=0; BUSY=0; DONE=0; RESULT=0; sample counter=0; bit index=WIDTH-1.
- State machine: IDLE, SAMPLE, CONVERT, DONE.
- When VENABLE=0 at a clock edge, nothing changes: state, counters, DAC_CODE, RESULT and outputs all hold, and VSTART/VCOMP are ignored. Every rule below applies only to edges where VENABLE=1.
- IDLE:
  - VSTART=1 moves the block to SAMPLE and clears the sample counter.
  - VSTART=0 keeps the block in IDLE.
  - DAC_CODE=0 in IDLE.
- SAMPLE:
  - SAMPLE=1 for exactly SAMPLE_CYCLES cycles, then the block moves to CONVERT.
  - On entering CONVERT: bit index = WIDTH-1, DAC_CODE = 1<<(WIDTH-1).
- CONVERT: one cycle per bit i, from WIDTH-1 down to 0.
  - During cycle i: BIT_SEL = 1<<i, and DAC_CODE = committed upper bits | (1<<i).
  - At the edge ending cycle i, VCOMP is sampled. VCOMP=1 keeps bit i; VCOMP=0 clears it.
  - Bit i-1 is then set as the next trial.
  - After bit 0 resolves, the final code is loaded into RESULT and the state moves to DONE.
- DONE:
  - DONE=1 and BUSY=0 for one enabled cycle. RESULT is already valid in this cycle.
  - DAC_CODE holds the final code.
  - Next state is SAMPLE if VCONT=1, otherwise IDLE.
- Latency: VSTART sampled at edge t0 puts DONE high in the cycle beginning at edge t0+SAMPLE_CYCLES+WIDTH (edge count with VENABLE=1).
- VSTART is ignored in SAMPLE, CONVERT and DONE. There is no queuing.
- VCONT is examined only in DONE. Deasserting it mid-conversion lets the current conversion finish, then the block returns to IDLE.
- VRESET mid-conversion aborts immediately and asynchronously to reset values. RESULT is cleared and no DONE is produced.
- Width rules: DAC_CODE and RESULT are unsigned WIDTH-bit values. The counter width is clog2(SAMPLE_CYCLES+1). No code values are out of range, so no overflow handling is needed.

Test Plan:
- WIDTH=8, SAMPLE_CYCLES=2, comparator model with input code 0xA5, VSTART pulse at t0.
  - SAMPLE high for cycles t0+1..t0+2 (relative to the t0 edge).
  - DAC_CODE sequence 80,C0,A0,B0,A8,A4,A6,A5.
  - DONE for 1 cycle at t0+10 with RESULT=0xA5, then IDLE with BUSY=0.
- VCOMP tied 1 gives RESULT=0xFF; VCOMP tied 0 gives RESULT=0x00 and DAC_CODE sequence 80,40,20,10,08,04,02,01. Each case takes 1 DONE pulse.
- VCONT=1 with the input code changing 0x3C then 0xC3: back-to-back DONE pulses 11 cycles apart (SAMPLE_CYCLES+WIDTH+1) with RESULT 0x3C then 0xC3. VSTART pulses during BUSY have no effect.
- VENABLE low for 3 cycles during bit 4 of a 0xA5 conversion: DAC_CODE and BIT_SEL frozen, DONE delayed by exactly 3 cycles, RESULT still 0xA5.
- VRESET asserted mid-CONVERT between clock edges: all outputs go to reset values immediately with no clock, RESULT=0. A subsequent VSTART produces a correct full conversion.
- Parameter sweep WIDTH=4/SAMPLE_CYCLES=1 and WIDTH=12/SAMPLE_CYCLES=4 with random input codes: RESULT equals the model code, and latency equals SAMPLE_CYCLES+WIDTH+1.

Source files
------------

// File: rtl/sar_ctrl.sv
// ---------------------------------------------------------------------------
// sar_ctrl -- N-bit successive-approximation conversion sequencer.
//
// Drives the sample switch and the capacitive-DAC trial code. It resolves one
// bit per clock from the comparator, MSB first, and publishes a registered
// result together with a one-cycle DONE pulse. It supports single-shot
// conversions (VSTART) and continuous conversions (VCONT).
//
// Ports
//   CLK        clock, rising edge
//   VRESET     asynchronous, active-high reset
//   VSTART     conversion request; only looked at while idle
//   VENABLE    1 = advance, 0 = freeze every register
//   VCONT      continuous mode; only looked at in the DONE state
//   VCOMP      comparator: 1 = analog input >= current DAC trial level
//   SAMPLE     sample-switch control; high in the SAMPLE state
//   DAC_CODE   trial code driven to the CDAC
//   BIT_SEL    one-hot mask of the bit under trial; 0 outside CONVERT
//   BUSY       high in the SAMPLE and CONVERT states
//   DONE       high in the DONE state; RESULT is valid there
//   RESULT     last completed conversion; held until the next DONE
//   state_dbg  current FSM state, for observation only
//
// Handshake: VSTART is a level request. It is accepted on an enabled edge
// in IDLE and ignored in every other state. Nothing is queued. Each
// conversion is reported by exactly one DONE state, and RESULT is already
// valid in that state.
// ---------------------------------------------------------------------------
module sar_ctrl #(
  parameter int WIDTH         = 8,
  parameter int SAMPLE_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             VRESET,
  input  logic             VSTART,
  input  logic             VENABLE,
  input  logic             VCONT,
  input  logic             VCOMP,
  output logic             SAMPLE,
  output logic [WIDTH-1:0] DAC_CODE,
  output logic [WIDTH-1:0] BIT_SEL,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic [1:0]       state_dbg
);

  localparam int CNT_W = $clog2(SAMPLE_CYCLES + 1);
  localparam int IDX_W = $clog2(WIDTH);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SAMPLE  = 2'd1;
  localparam logic [1:0] ST_CONVERT = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] MSB      = ONE << (WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [WIDTH-1:0] dac_q, dac_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [WIDTH-1:0] bit_onehot;
  logic [WIDTH-1:0] resolved;

  always_comb begin
    bit_onehot = ONE << bit_idx_q;
    // The bit under trial is already set in dac_q. A low comparator means
    // the trial level overshot the input, so that bit is dropped.
    resolved   = VCOMP ? dac_q : (dac_q & ~bit_onehot);

    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    dac_d     = dac_q;
    result_d  = result_q;

    if (VENABLE) begin
      case (state_q)
        ST_IDLE: begin
          dac_d = '0;
          if (VSTART) begin
            state_d = ST_SAMPLE;
            cnt_d   = '0;
          end
        end

        ST_SAMPLE: begin
          if (cnt_q == CNT_LAST) begin
            state_d   = ST_CONVERT;
            cnt_d     = '0;
            bit_idx_d = IDX_TOP;
            dac_d     = MSB;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        ST_CONVERT: begin
          if (bit_idx_q == '0) begin
            dac_d    = resolved;
            result_d = resolved;
            state_d  = ST_DONE;
          end else begin
            // Commit this bit and immediately put the next lower bit on trial.
            dac_d     = resolved | (bit_onehot >> 1);
            bit_idx_d = bit_idx_q - IDX_W'(1);
          end
        end

        ST_DONE: begin
          bit_idx_d = IDX_TOP;
          dac_d     = '0;
          cnt_d     = '0;
          state_d   = VCONT ? ST_SAMPLE : ST_IDLE;
        end

        default: begin
          state_d = ST_IDLE;
          dac_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge VRESET) begin
    if (VRESET) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= IDX_TOP;
      dac_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      dac_q     <= dac_d;
      result_q  <= result_d;
    end
  end

  // The outputs are decoded straight from registered state, so the
  // asynchronous reset reaches them without waiting for a clock edge.
  always_comb begin
    SAMPLE    = (state_q == ST_SAMPLE);
    BUSY      = (state_q == ST_SAMPLE) || (state_q == ST_CONVERT);
    DONE      = (state_q == ST_DONE);
    BIT_SEL   = (state_q == ST_CONVERT) ? bit_onehot : '0;
    DAC_CODE  = dac_q;
    RESULT    = result_q;
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_sar_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sar_ctrl -- directed bench for sar_ctrl.
//
// One 8-bit / 2-sample instance carries the main scenarios. A 4/1 instance
// and a 12/4 instance cover the parameter sweep with random input codes.
// The comparator is modelled as (vin >= DAC_CODE), or it is tied high or low.
// ---------------------------------------------------------------------------
module tb_sar_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic vreset;
  logic venable;
  logic vcont;

  // 8-bit instance
  logic        vstart8;
  logic [7:0]  vin8;
  int          comp_mode;  // 0 = model, 1 = tied high, 2 = tied low
  logic        vcomp8;
  logic        s8, busy8, done8;
  logic [7:0]  dac8, bs8, res8;
  logic [1:0]  st8;

  // 4-bit instance
  logic        vstart4;
  logic [3:0]  vin4;
  logic        vcomp4;
  logic        s4, busy4, done4;
  logic [3:0]  dac4, bs4, res4;
  logic [1:0]  st4;

  // 12-bit instance
  logic        vstart12;
  logic [11:0] vin12;
  logic        vcomp12;
  logic        s12, busy12, done12;
  logic [11:0] dac12, bs12, res12;
  logic [1:0]  st12;

  assign vcomp8  = (comp_mode == 1) ? 1'b1 : (comp_mode == 2) ? 1'b0 : (vin8 >= dac8);
  assign vcomp4  = (vin4 >= dac4);
  assign vcomp12 = (vin12 >= dac12);

  sar_ctrl #(.WIDTH(8), .SAMPLE_CYCLES(2)) u_dut8 (
    .CLK(clk), .VRESET(vreset), .VSTART(vstart8), .VENABLE(venable),
    .VCONT(vcont), .VCOMP(vcomp8), .SAMPLE(s8), .DAC_CODE(dac8),
    .BIT_SEL(bs8), .BUSY(busy8), .DONE(done8), .RESULT(res8),
    .state_dbg(st8)
  );

  sar_ctrl #(.WIDTH(4), .SAMPLE_CYCLES(1)) u_dut4 (
    .CLK(clk), .VRESET(vreset), .VSTART(vstart4), .VENABLE(venable),
    .VCONT(1'b0), .VCOMP(vcomp4), .SAMPLE(s4), .DAC_CODE(dac4),
    .BIT_SEL(bs4), .BUSY(busy4), .DONE(done4), .RESULT(res4),
    .state_dbg(st4)
  );

  sar_ctrl #(.WIDTH(12), .SAMPLE_CYCLES(4)) u_dut12 (
    .CLK(clk), .VRESET(vreset), .VSTART(vstart12), .VENABLE(venable),
    .VCONT(1'b0), .VCOMP(vcomp12), .SAMPLE(s12), .DAC_CODE(dac12),
    .BIT_SEL(bs12), .BUSY(busy12), .DONE(done12), .RESULT(res12),
    .state_dbg(st12)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done8(output int n);
    n = 0;
    while (done8 !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("done8_seen", done8, 1);
  endtask

  // Full 8-bit conversion, checking every trial code against a hand table.
  task automatic trace8(input string tag, input logic [63:0] seq, input logic [7:0] exp_res);
    vstart8 = 1'b1;
    tick();
    vstart8 = 1'b0;
    chk({tag, "_sample1"}, s8, 1);
    chk({tag, "_busy_s"}, busy8, 1);
    tick();
    chk({tag, "_sample2"}, s8, 1);
    tick();
    chk({tag, "_sample_off"}, s8, 0);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("%s_dac%0d", tag, k), dac8, seq[63-8*k -: 8]);
      chk($sformatf("%s_bs%0d", tag, k), bs8, 8'h80 >> k);
      tick();
    end
    chk({tag, "_done"}, done8, 1);
    chk({tag, "_busy_d"}, busy8, 0);
    chk({tag, "_result"}, res8, exp_res);
    chk({tag, "_dac_final"}, dac8, exp_res);
    tick();
    chk({tag, "_done_off"}, done8, 0);
    chk({tag, "_idle"}, st8, 0);
    chk({tag, "_dac_idle"}, dac8, 0);
  endtask

  initial begin
    int n;
    logic [3:0]  code4;
    logic [11:0] code12;

    vreset    = 1'b1;
    venable   = 1'b1;
    vcont     = 1'b0;
    vstart8   = 1'b0;
    vstart4   = 1'b0;
    vstart12  = 1'b0;
    vin8      = 8'h00;
    vin4      = 4'h0;
    vin12     = 12'h000;
    comp_mode = 0;
    repeat (3) @(posedge clk);
    #3;
    vreset = 1'b0;
    tick();

    // Reset values
    chk("rst_sample", s8, 0);
    chk("rst_dac", dac8, 0);
    chk("rst_bitsel", bs8, 0);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_result", res8, 0);
    chk("rst_state", st8, 0);

    // Main conversion with input 0xA5, then the two tied-comparator cases
    vin8 = 8'hA5;
    trace8("a5", 64'h80C0A0B0A8A4A6A5, 8'hA5);
    comp_mode = 1;
    trace8("ones", 64'h80C0E0F0F8FCFEFF, 8'hFF);
    comp_mode = 2;
    trace8("zeros", 64'h8040201008040201, 8'h00);
    comp_mode = 0;

    // Continuous mode: 0x3C then 0xC3, with DONE pulses 11 cycles apart
    vcont   = 1'b1;
    vin8    = 8'h3C;
    vstart8 = 1'b1;
    tick();
    vstart8 = 1'b0;
    wait_done8(n);
    chk("cont_lat1", n, 10);
    chk("cont_res1", res8, 8'h3C);
    vin8 = 8'hC3;
    tick();
    chk("cont_resample", s8, 1);
    vstart8 = 1'b1;  // ignored while busy
    tick();
    tick();
    vstart8 = 1'b0;
    vcont   = 1'b0;  // current conversion completes, then the block idles
    wait_done8(n);
    chk("cont_gap", n + 3, 11);
    chk("cont_res2", res8, 8'hC3);
    tick();
    chk("cont_stop_busy", busy8, 0);
    chk("cont_stop_state", st8, 0);
    tick();
    chk("cont_no_queue", busy8, 0);

    // Freeze for 3 cycles while bit 4 is under trial
    vin8    = 8'hA5;
    vstart8 = 1'b1;
    tick();
    vstart8 = 1'b0;
    repeat (5) tick();
    chk("frz_dac_pre", dac8, 8'hB0);
    chk("frz_bs_pre", bs8, 8'h10);
    venable   = 1'b0;
    comp_mode = 2;  // ignored while frozen
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("frz_dac%0d", k), dac8, 8'hB0);
      chk($sformatf("frz_bs%0d", k), bs8, 8'h10);
    end
    venable   = 1'b1;
    comp_mode = 0;
    wait_done8(n);
    chk("frz_latency", 5 + 3 + n, 13);
    chk("frz_result", res8, 8'hA5);
    tick();

    // Asynchronous reset in the middle of CONVERT
    vstart8 = 1'b1;
    tick();
    vstart8 = 1'b0;
    repeat (4) tick();
    chk("ar_pre_busy", busy8, 1);
    #3;
    vreset = 1'b1;
    #1;
    chk("ar_sample", s8, 0);
    chk("ar_dac", dac8, 0);
    chk("ar_bitsel", bs8, 0);
    chk("ar_busy", busy8, 0);
    chk("ar_done", done8, 0);
    chk("ar_result", res8, 0);
    chk("ar_state", st8, 0);
    #1;
    vreset = 1'b0;
    trace8("post_rst", 64'h80C0A0B0A8A4A6A5, 8'hA5);

    // Sweep: WIDTH=4/SAMPLE_CYCLES=1 and WIDTH=12/SAMPLE_CYCLES=4.
    // Latency counts the VSTART edge plus every edge up to the one that
    // raises DONE.
    for (int i = 0; i < 4; i++) begin
      code4    = 4'($urandom_range(0, 15));
      vin4     = code4;
      vstart4  = 1'b1;
      tick();
      vstart4  = 1'b0;
      n = 0;
      while (done4 !== 1'b1 && n < 200) begin
        tick();
        n++;
      end
      chk($sformatf("w4_done%0d", i), done4, 1);
      chk($sformatf("w4_lat%0d", i), n + 1, 6);
      chk($sformatf("w4_res%0d", i), res4, code4);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      code12   = 12'($urandom_range(0, 4095));
      vin12    = code12;
      vstart12 = 1'b1;
      tick();
      vstart12 = 1'b0;
      n = 0;
      while (done12 !== 1'b1 && n < 200) begin
        tick();
        n++;
      end
      chk($sformatf("w12_done%0d", i), done12, 1);
      chk($sformatf("w12_lat%0d", i), n + 1, 17);
      chk($sformatf("w12_res%0d", i), res12, code12);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
